// File: rtl/iob_bus_arbiter_rr_if.sv
// rtl/iob_bus_arbiter_rr_if.sv - IOb bus bundle with N flattened lanes, master/slave views
interface iob_bus_arbiter_rr_if #(
    parameter int N      = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [N-1:0]              avalid;
    logic [N*ADDR_W-1:0]       addr;
    logic [N*DATA_W-1:0]       wdata;
    logic [N*(DATA_W/8)-1:0]   wstrb;
    logic [N*DATA_W-1:0]       rdata;
    logic [N-1:0]              rvalid;
    logic [N-1:0]              ready;

    modport master (
        output avalid, addr, wdata, wstrb,
        input  rdata, rvalid, ready
    );

    modport slave (
        input  avalid, addr, wdata, wstrb,
        output rdata, rvalid, ready
    );
endinterface

// File: rtl/iob_bus_arbiter_rr.sv
// rtl/iob_bus_arbiter_rr.sv - round-robin IOb arbiter, one outstanding transaction; optional IOB_ARB_TIMEOUT_EN read timeout
module iob_bus_arbiter_rr #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  rst_i,
    iob_bus_arbiter_rr_if.slave   s_bus,
    iob_bus_arbiter_rr_if.master  m_bus,
    output logic                  timeout_o
);
    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_WAIT_R = 2'd2
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_owner;

    logic [PTR_W-1:0]    w_win;
    logic                w_win_vld;
    logic [PTR_W-1:0]    w_sel;
    logic                w_sel_vld;
    logic                w_is_wr;
    logic                w_accept;
    logic                w_tmo_fire;
    logic                w_rsp;
    logic [DATA_W-1:0]   w_rslot;

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] k);
        return (k == PTR_W'(NUM_REQ - 1)) ? '0 : k + 1'b1;
    endfunction

    // Rotating priority search starting at r_ptr; lower offsets overwrite later so the nearest wins
    always_comb begin
        int j;
        j         = 0;
        w_win     = '0;
        w_win_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(r_ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (s_bus.avalid[j]) begin
                w_win     = PTR_W'(j);
                w_win_vld = 1'b1;
            end
        end
    end

    // In IDLE the fresh winner drives the downstream port; in HOLD the locked owner does
    always_comb begin
        w_sel     = (r_state == ST_IDLE) ? w_win : r_owner;
        w_sel_vld = 1'b0;
        case (r_state)
            ST_IDLE: w_sel_vld = w_win_vld;
            ST_HOLD: w_sel_vld = s_bus.avalid[r_owner];
            default: w_sel_vld = 1'b0;
        endcase
    end

    assign m_bus.avalid = w_sel_vld;
    assign m_bus.addr   = s_bus.addr[int'(w_sel)*ADDR_W +: ADDR_W];
    assign m_bus.wdata  = s_bus.wdata[int'(w_sel)*DATA_W +: DATA_W];
    assign m_bus.wstrb  = s_bus.wstrb[int'(w_sel)*STRB_W +: STRB_W];
    assign w_is_wr      = |s_bus.wstrb[int'(w_sel)*STRB_W +: STRB_W];
    assign w_accept     = w_sel_vld & m_bus.ready[0];
    assign s_bus.ready  = w_accept ? (NUM_REQ'(1) << w_sel) : '0;

`ifdef IOB_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_cnt;

    // Counts cycles spent in WAIT_R; held at zero everywhere else so entry always starts fresh
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (cke_i) begin
            r_cnt <= (r_state == ST_WAIT_R) ? r_cnt + 1'b1 : '0;
        end
    end

    // A real rvalid in the expiry cycle takes precedence over the timeout
    assign w_tmo_fire = (r_state == ST_WAIT_R) && (&r_cnt) && !m_bus.rvalid[0];
`else
    assign w_tmo_fire = 1'b0;
`endif

    assign timeout_o    = w_tmo_fire;
    assign w_rsp        = (r_state == ST_WAIT_R) && (m_bus.rvalid[0] || w_tmo_fire);
    assign w_rslot      = w_tmo_fire ? {DATA_W{1'b1}} : m_bus.rdata;
    assign s_bus.rdata  = {NUM_REQ{w_rslot}};
    assign s_bus.rvalid = w_rsp ? (NUM_REQ'(1) << r_owner) : '0;

    // Transaction FSM: owner lock, round-robin pointer update and read-response wait
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else if (cke_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win_vld) begin
                        r_owner <= w_win;
                        if (m_bus.ready[0]) begin
                            if (w_is_wr) r_ptr   <= f_next(w_win);
                            else         r_state <= ST_WAIT_R;
                        end else begin
                            r_state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!s_bus.avalid[r_owner]) begin
                        r_state <= ST_IDLE;
                    end else if (m_bus.ready[0]) begin
                        if (w_is_wr) begin
                            r_ptr   <= f_next(r_owner);
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT_R;
                        end
                    end
                end
                ST_WAIT_R: begin
                    if (w_rsp) begin
                        r_ptr   <= f_next(r_owner);
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
